// File: rtl/neuron_layer_seq_pkg.sv
// neuron_layer_seq_pkg
//   Shared definitions for the sequential neuron layer: activation-mode
//   encodings, the controller state type and the Q-format constants.
//   No ports.
package neuron_layer_seq_pkg;

   typedef enum logic [1:0] {
      ACT_LINEAR = 2'd0,
      ACT_RELU   = 2'd1,
      ACT_HSIG   = 2'd2,
      ACT_STEP   = 2'd3
   } act_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BIAS,
      ST_MAC,
      ST_ACT,
      ST_OUT
   } state_t;

   localparam int FRAC_W_DEF = 8;

   // Fixed-point 1.0 and 0.5 for a given number of fractional bits.
   function automatic int unsigned q_one(input int unsigned frac_w);
      return 32'd1 << frac_w;
   endfunction

   function automatic int unsigned q_half(input int unsigned frac_w);
      return 32'd1 << (frac_w - 1);
   endfunction

   localparam int unsigned ONE  = q_one(FRAC_W_DEF);
   localparam int unsigned HALF = q_half(FRAC_W_DEF);

endpackage

// File: rtl/neuron_layer_seq_if.sv
// neuron_layer_seq_if
//   Streaming interface of the neuron layer.
//   in_valid/in_ready/in_data/act_mode : input vector handshake (+ mode)
//   out_valid/out_ready/out_data       : result vector handshake
//   modport master : producer/consumer side (drives in_*, out_ready)
//   modport slave  : layer side (drives in_ready, out_valid, out_data)
interface neuron_layer_seq_if #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int DATA_W = 16
);
   import neuron_layer_seq_pkg::*;

   logic                      in_valid;
   logic                      in_ready;
   logic [N_IN*DATA_W-1:0]    in_data;
   act_mode_t                 act_mode;
   logic                      out_valid;
   logic                      out_ready;
   logic [N_OUT*DATA_W-1:0]   out_data;

   modport master (
      output in_valid, in_data, act_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, act_mode, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/neuron_layer_seq_act.sv
// neuron_act
//   Combinational activation stage: arithmetic right shift of the
//   accumulator by FRAC_W (floor), saturation to DATA_W, then the
//   selected activation.
//   acc  : accumulator value (ACC_W, signed, 2*FRAC_W fractional bits)
//   mode : activation select
//   y    : activated result (DATA_W, signed, FRAC_W fractional bits)
module neuron_act
   import neuron_layer_seq_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int ACC_W  = 2*DATA_W + 2
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  act_mode_t                mode,
   output logic signed [DATA_W-1:0] y
);

   localparam logic signed [DATA_W-1:0] MAX_D = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] MIN_D = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W:0]   ONE_W  = (DATA_W+1)'(q_one(FRAC_W));
   localparam logic signed [DATA_W:0]   HALF_W = (DATA_W+1)'(q_half(FRAC_W));

   logic signed [ACC_W-1:0]  s_wide;
   logic signed [DATA_W-1:0] s;
   logic signed [DATA_W:0]   hs;

   always_comb begin
      s_wide = acc >>> FRAC_W;
      if (s_wide > ACC_W'(MAX_D))
         s = MAX_D;
      else if (s_wide < ACC_W'(MIN_D))
         s = MIN_D;
      else
         s = s_wide[DATA_W-1:0];

      // one extra bit so s/4 + 0.5 cannot wrap before clamping
      hs = (DATA_W+1)'(s >>> 2) + HALF_W;

      y = '0;
      case (mode)
         ACT_LINEAR: y = s;
         ACT_RELU:   y = (s < 0) ? '0 : s;
         ACT_HSIG: begin
            if (hs < 0)
               y = '0;
            else if (hs > ONE_W)
               y = ONE_W[DATA_W-1:0];
            else
               y = hs[DATA_W-1:0];
         end
         ACT_STEP:   y = (s > 0) ? ONE_W[DATA_W-1:0] : '0;
         default:    y = s;
      endcase
   end

endmodule

// File: rtl/neuron_layer_seq.sv
// neuron_layer_seq
//   Fully-connected neuron layer computed with one shared multiply-
//   accumulate unit, one neuron at a time (bias cycle, N_IN MAC cycles,
//   one activation cycle per neuron).
//   clk, rst         : clock, asynchronous active-high reset
//   w_wr_en/w_addr/w_data : weight/bias write port, entry
//                      neuron*(N_IN+1)+k, k=N_IN is the bias; IDLE only
//   bus (slave)      : input vector / result vector handshakes
module neuron_layer_seq
   import neuron_layer_seq_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   localparam int N_W    = N_OUT*(N_IN+1),
   localparam int ADDR_W = (N_W > 1) ? $clog2(N_W) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_wr_en,
   input  logic [ADDR_W-1:0]        w_addr,
   input  logic signed [DATA_W-1:0] w_data,
   neuron_layer_seq_if.slave        bus
);

   localparam int ACC_W = 2*DATA_W + $clog2(N_IN+1);
   localparam int IW    = (N_IN  > 1) ? $clog2(N_IN)  : 1;
   localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [ADDR_W:0] N_W_L  = (ADDR_W+1)'(N_W);
   localparam logic [IW-1:0]   I_LAST = IW'(N_IN-1);
   localparam logic [JW-1:0]   J_LAST = JW'(N_OUT-1);

   state_t state, state_nx;

   logic signed [DATA_W-1:0]   wmem [N_W];
   logic signed [DATA_W-1:0]   xr   [N_IN];
   act_mode_t                  mode_r;
   logic signed [ACC_W-1:0]    acc;
   logic [IW-1:0]              i;
   logic [JW-1:0]              j;
   logic [ADDR_W-1:0]          base;
   logic [N_OUT*DATA_W-1:0]    out_r;

   logic [ADDR_W-1:0]          rd_addr;
   logic signed [DATA_W-1:0]   w_rd;
   logic signed [DATA_W-1:0]   x_sel;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [DATA_W-1:0]   act_y;
   logic                       accept;
   logic                       wr_ok;

   assign accept = bus.in_valid && (state == ST_IDLE);
   assign wr_ok  = w_wr_en && (state == ST_IDLE) && ({1'b0, w_addr} < N_W_L);
   assign bus.out_data = out_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      bus.in_ready = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid)
               state_nx = ST_BIAS;
         end
         ST_BIAS: state_nx = ST_MAC;
         ST_MAC:  if (i == I_LAST) state_nx = ST_ACT;
         ST_ACT:  state_nx = (j == J_LAST) ? ST_OUT : ST_BIAS;
         ST_OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready)
               state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Shared MAC read path: base tracks j*(N_IN+1) incrementally so no
   // runtime multiply is needed for the address.
   always_comb begin
      rd_addr = base + ((state == ST_BIAS) ? ADDR_W'(N_IN) : ADDR_W'(i));
      w_rd    = wmem[rd_addr];
      x_sel   = xr[i];
      prod    = (2*DATA_W)'(w_rd) * (2*DATA_W)'(x_sel);
   end

   neuron_act #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_act (
      .acc  (acc),
      .mode (mode_r),
      .y    (act_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < N_W; k++)
            wmem[k] <= '0;
         for (int unsigned k = 0; k < N_IN; k++)
            xr[k] <= '0;
         mode_r <= ACT_LINEAR;
         acc    <= '0;
         i      <= '0;
         j      <= '0;
         base   <= '0;
         out_r  <= '0;
      end else begin
         if (wr_ok)
            wmem[w_addr] <= w_data;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  for (int unsigned k = 0; k < N_IN; k++)
                     xr[k] <= bus.in_data[k*DATA_W +: DATA_W];
                  mode_r <= bus.act_mode;
                  j      <= '0;
                  base   <= '0;
               end
            end
            ST_BIAS: begin
               acc <= ACC_W'(w_rd) <<< FRAC_W;
               i   <= '0;
            end
            ST_MAC: begin
               acc <= acc + ACC_W'(prod);
               i   <= (i == I_LAST) ? '0 : i + 1'b1;
            end
            ST_ACT: begin
               out_r[j*DATA_W +: DATA_W] <= act_y;
               j    <= (j == J_LAST) ? '0 : j + 1'b1;
               base <= base + ADDR_W'(N_IN+1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_layer_seq.sv
// tb_neuron_layer_seq
//   Directed scoreboard bench for neuron_layer_seq (N_IN=3, N_OUT=2, Q8.8).
//   The stimulus process pushes the expected result vector at each accept;
//   a monitor pops and compares at every output handshake and also checks
//   the accept-to-valid latency.
module tb_neuron_layer_seq;
   import neuron_layer_seq_pkg::*;

   localparam int N_IN = 3;
   localparam int N_OUT = 2;
   localparam int DW = 16;
   localparam int LAT = N_OUT*(N_IN+2);

   typedef struct {
      logic [31:0] data;
      int unsigned acc_cyc;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        w_wr_en;
   logic [2:0]  w_addr;
   logic [15:0] w_data;

   neuron_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW)) bus ();

   neuron_layer_seq #(
      .N_IN   (N_IN),
      .N_OUT  (N_OUT),
      .DATA_W (DW),
      .FRAC_W (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .w_wr_en (w_wr_en),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;
   exp_t sb[$];
   bit seen = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (rst) begin
         seen = 0;
      end else begin
         if (bus.out_valid && !seen) begin
            seen = 1;
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_output: got %h expected none", bus.out_data);
            end else
               check({"lat_", sb[0].name}, cyc - sb[0].acc_cyc, LAT);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() != 0) begin
               check(sb[0].name, bus.out_data, sb[0].data);
               void'(sb.pop_front());
            end
            seen = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      w_wr_en = 1'b1; w_addr = a; w_data = d;
      tick();
      w_wr_en = 1'b0;
   endtask

   task automatic load_n(input logic [2:0] n, input logic [15:0] w0, w1, w2, b);
      wr(3'(n*4 + 0), w0);
      wr(3'(n*4 + 1), w1);
      wr(3'(n*4 + 2), w2);
      wr(3'(n*4 + 3), b);
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while (sb.size() != 0 && n < 200) begin tick(); n++; end
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain_%s: got pending=%0d expected 0", nm, sb.size());
         sb.delete();
      end
   endtask

   task automatic send(input string nm, input logic [15:0] x0, x1, x2, input act_mode_t m,
                       input logic [15:0] e0, e1, input bit drain = 1'b1,
                       input bit co_wr = 1'b0, input logic [2:0] ca = '0, input logic [15:0] cd = '0);
      exp_t e;
      int n = 0;
      while (!bus.in_ready && n < 50) begin tick(); n++; end
      if (!bus.in_ready) begin
         total++; bad++;
         $display("FAIL ready_%s: got in_ready=0 expected 1", nm);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = {x2, x1, x0};
      bus.act_mode = m;
      if (co_wr) begin w_wr_en = 1'b1; w_addr = ca; w_data = cd; end
      tick();
      bus.in_valid = 1'b0;
      w_wr_en = 1'b0;
      e.data = {e1, e0}; e.acc_cyc = cyc; e.name = nm;
      sb.push_back(e);
      if (drain) wait_drain(nm);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] h0, h1, a, y, par;
      logic [15:0] xv0, xv1, xv2;
      int n;
      rst = 1'b1; w_wr_en = 1'b0; w_addr = '0; w_data = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.act_mode = ACT_LINEAR; bus.out_ready = 1'b1;
      tick(); tick();
      check("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_data",  bus.out_data, 32'h0);
      rst = 1'b0;
      tick();

      // plain linear
      for (int k = 0; k < 2; k++) load_n(3'(k), 16'h0100, 16'h0100, 16'h0100, 16'h0000);
      send("lin_ones", 16'h0100, 16'h0100, 16'h0100, ACT_LINEAR, 16'h0300, 16'h0300);
      // bias write in the accept cycle is used by this run
      send("co_write", 16'h0100, 16'h0100, 16'h0100, ACT_LINEAR, 16'h0400, 16'h0300,
           1'b1, 1'b1, 3'd3, 16'h0100);

      // reset mid-MAC
      bus.in_valid = 1'b1; bus.in_data = {3{16'h0100}}; bus.act_mode = ACT_LINEAR;
      tick();
      bus.in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      check("abort_in_ready",  {31'b0, bus.in_ready},  32'd1);
      check("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("abort_out_data",  bus.out_data, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      send("post_rst", 16'h0100, 16'h0100, 16'h0100, ACT_LINEAR, 16'h0000, 16'h0000);

      // mixed signs, floor
      load_n(3'd0, 16'h0180, 16'hFF00, 16'h0040, 16'h0010);
      load_n(3'd1, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0000);
      send("mix_lin",  16'h0200, 16'h0080, 16'hFFFF, ACT_LINEAR, 16'h028F, 16'hFD81);
      send("mix_relu", 16'h0200, 16'h0080, 16'hFFFF, ACT_RELU,   16'h028F, 16'h0000);

      // saturation
      for (int k = 0; k < 2; k++) load_n(3'(k), 16'h7F00, 16'h7F00, 16'h7F00, 16'h0000);
      send("sat_pos", 16'h7F00, 16'h7F00, 16'h7F00, ACT_LINEAR, 16'h7FFF, 16'h7FFF);
      for (int k = 0; k < 2; k++) load_n(3'(k), 16'h8100, 16'h8100, 16'h8100, 16'h0000);
      send("sat_neg",  16'h7F00, 16'h7F00, 16'h7F00, ACT_LINEAR, 16'h8000, 16'h8000);
      send("sat_relu", 16'h7F00, 16'h7F00, 16'h7F00, ACT_RELU,   16'h0000, 16'h0000);

      // hard-sigmoid / step via bias only
      load_n(3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      load_n(3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0400);
      send("hsig_a", 16'h0100, 16'h0100, 16'h0100, ACT_HSIG, 16'h0080, 16'h0100);
      send("step_a", 16'h0100, 16'h0100, 16'h0100, ACT_STEP, 16'h0000, 16'h0100);
      wr(3'd3, 16'hFC00);
      send("hsig_b", 16'h0100, 16'h0100, 16'h0100, ACT_HSIG, 16'h0000, 16'h0100);
      send("step_b", 16'h0100, 16'h0100, 16'h0100, ACT_STEP, 16'h0000, 16'h0100);

      // backpressure
      load_n(3'd0, 16'h0180, 16'hFF00, 16'h0040, 16'h0010);
      load_n(3'd1, 16'hFF00, 16'hFF00, 16'hFF00, 16'h0000);
      bus.out_ready = 1'b0;
      send("bp_hold", 16'h0200, 16'h0080, 16'hFFFF, ACT_LINEAR, 16'h028F, 16'hFD81, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 30) begin tick(); n++; end
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = 1'b1; bus.in_data = {3{16'h0300}};
         w_wr_en = 1'b1; w_addr = 3'd0; w_data = 16'h7F00;
         tick();
         check("bp_data",      bus.out_data, {16'hFD81, 16'h028F});
         check("bp_in_ready",  {31'b0, bus.in_ready},  32'd0);
         check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      end
      bus.in_valid = 1'b0; w_wr_en = 1'b0;
      bus.out_ready = 1'b1;
      wait_drain("bp_hold");
      for (int c = 0; c < 15; c++) tick();
      check("bp_no_extra", {31'b0, bus.out_valid}, 32'd0);
      send("bp_wr_ignored", 16'h0200, 16'h0080, 16'hFFFF, ACT_LINEAR, 16'h028F, 16'hFD81);

      // XOR-3 as two cascaded XOR-2 stages (OR/NAND hidden pair, AND output)
      for (int p = 0; p < 8; p++) begin
         xv0 = p[0] ? 16'h0100 : 16'h0000;
         xv1 = p[1] ? 16'h0100 : 16'h0000;
         xv2 = p[2] ? 16'h0100 : 16'h0000;
         for (int st = 0; st < 2; st++) begin
            a = (st == 0) ? xv0 : y;
            h0 = ((st == 0 ? p[0] : y[8]) | (st == 0 ? p[1] : p[2])) ? 16'h0100 : 16'h0000;
            h1 = ((st == 0 ? p[0] : y[8]) & (st == 0 ? p[1] : p[2])) ? 16'h0000 : 16'h0100;
            load_n(3'd0, 16'h0100, 16'h0100, 16'h0000, 16'hFF80);
            load_n(3'd1, 16'hFF00, 16'hFF00, 16'h0000, 16'h0180);
            send("xor_hidden", a, (st == 0) ? xv1 : xv2, 16'h0000, ACT_STEP, h0, h1);
            load_n(3'd0, 16'h0100, 16'h0100, 16'h0000, 16'hFE80);
            load_n(3'd1, 16'h0100, 16'h0100, 16'h0000, 16'hFE80);
            if (st == 0) begin
               y = (p[0] ^ p[1]) ? 16'h0100 : 16'h0000;
               send("xor2_out", h0, h1, 16'h0000, ACT_STEP, y, y);
            end else begin
               par = (p[0] ^ p[1] ^ p[2]) ? 16'h0100 : 16'h0000;
               send("xor3_parity", h0, h1, 16'h0000, ACT_STEP, par, par);
            end
         end
      end

      for (int c = 0; c < 5; c++) tick();
      check("sb_empty", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
